// File: rtl/msdff_univ_reg.sv
// WIDTH-bit universal register: hold, load, shift, rotate and up/down count,
// with complementary output, registered serial out and terminal-count pulse.
module msdff_univ_reg #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic             C,
    input  logic             R,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             SO,
    output logic             TC
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_UP   = 3'b110;
    localparam logic [2:0] MODE_DN   = 3'b111;

    localparam logic [WIDTH-1:0] RST_Q    = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    // Qbar is derived from Q so the two can never disagree.
    assign Qbar = ~Q;

    always_ff @(posedge C) begin
        if (R) begin
            Q  <= RST_Q;
            SO <= 1'b0;
            TC <= 1'b0;
        end else begin
            TC <= 1'b0;
            if (EN) begin
                case (MODE)
                    MODE_HOLD: Q <= Q;
                    MODE_LOAD: Q <= D;
                    MODE_SHL: begin
                        Q  <= {Q[WIDTH-2:0], SIL};
                        SO <= Q[WIDTH-1];
                    end
                    MODE_SHR: begin
                        Q  <= {SIR, Q[WIDTH-1:1]};
                        SO <= Q[0];
                    end
                    MODE_ROL: begin
                        Q  <= {Q[WIDTH-2:0], Q[WIDTH-1]};
                        SO <= Q[WIDTH-1];
                    end
                    MODE_ROR: begin
                        Q  <= {Q[0], Q[WIDTH-1:1]};
                        SO <= Q[0];
                    end
                    MODE_UP: begin
                        Q  <= Q + ONE;
                        TC <= (Q == ALL_ONES);
                    end
                    MODE_DN: begin
                        Q  <= Q - ONE;
                        TC <= (Q == ZERO);
                    end
                    default: Q <= Q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msdff_univ_reg.sv
// Bench for msdff_univ_reg (WIDTH=4, RESET_VAL=4'hA): directed vector table
// followed by randomized traffic against an arithmetic reference model.
module tb_msdff_univ_reg;

    logic       C = 1'b0;
    logic       R, EN, SIL, SIR;
    logic [2:0] MODE;
    logic [3:0] D;
    logic [3:0] Q, Qbar;
    logic       SO, TC;

    int checks   = 0;
    int failures = 0;

    msdff_univ_reg #(.WIDTH(4), .RESET_VAL(32'hA)) dut (
        .C(C), .R(R), .EN(EN), .MODE(MODE), .D(D), .SIL(SIL), .SIR(SIR),
        .Q(Q), .Qbar(Qbar), .SO(SO), .TC(TC)
    );

    always #5 C = ~C;

    typedef struct {
        logic       r, en;
        logic [2:0] mode;
        logic [3:0] d;
        logic       sil, sir;
        logic [3:0] q;
        logic       so, tc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic en, logic [2:0] mode, logic [3:0] d,
                                logic sil, logic sir, logic [3:0] q, logic so, logic tc);
        vec_t v;
        v.r = r; v.en = en; v.mode = mode; v.d = d; v.sil = sil; v.sir = sir;
        v.q = q; v.so = so; v.tc = tc;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(logic r, logic en, logic [2:0] mode, logic [3:0] d,
                         logic sil, logic sir);
        @(negedge C);
        R = r; EN = en; MODE = mode; D = d; SIL = sil; SIR = sir;
        @(posedge C);
        #1;
    endtask

    // Reference model state
    int mq, mso, mtc, old;

    initial begin
        R = 1'b0; EN = 1'b0; MODE = 3'b000; D = 4'h0; SIL = 1'b0; SIR = 1'b0;

        // r en mode d sil sir | q so tc
        vecs.push_back(mk(1, 1, 3'b001, 4'h3, 0, 0, 4'hA, 0, 0)); // reset beats load
        vecs.push_back(mk(0, 1, 3'b001, 4'h9, 1, 1, 4'h9, 0, 0));
        vecs.push_back(mk(0, 1, 3'b010, 4'h0, 0, 1, 4'h2, 1, 0));
        vecs.push_back(mk(0, 1, 3'b011, 4'h0, 0, 1, 4'h9, 0, 0));
        vecs.push_back(mk(0, 1, 3'b001, 4'h8, 0, 0, 4'h8, 0, 0));
        vecs.push_back(mk(0, 1, 3'b100, 4'h0, 0, 1, 4'h1, 1, 0));
        vecs.push_back(mk(0, 1, 3'b100, 4'h0, 1, 0, 4'h2, 0, 0));
        vecs.push_back(mk(0, 1, 3'b100, 4'h0, 0, 0, 4'h4, 0, 0));
        vecs.push_back(mk(0, 1, 3'b100, 4'h0, 0, 0, 4'h8, 0, 0));
        vecs.push_back(mk(0, 1, 3'b001, 4'h1, 0, 0, 4'h1, 0, 0));
        vecs.push_back(mk(0, 1, 3'b101, 4'h0, 0, 0, 4'h8, 1, 0));
        vecs.push_back(mk(0, 1, 3'b001, 4'hE, 0, 0, 4'hE, 1, 0));
        vecs.push_back(mk(0, 1, 3'b110, 4'h0, 0, 0, 4'hF, 1, 0));
        vecs.push_back(mk(0, 1, 3'b110, 4'h0, 0, 0, 4'h0, 1, 1)); // up wrap
        vecs.push_back(mk(0, 1, 3'b110, 4'h0, 0, 0, 4'h1, 1, 0));
        vecs.push_back(mk(0, 1, 3'b001, 4'h1, 0, 0, 4'h1, 1, 0));
        vecs.push_back(mk(0, 1, 3'b111, 4'h0, 0, 0, 4'h0, 1, 0));
        vecs.push_back(mk(0, 1, 3'b111, 4'h0, 0, 0, 4'hF, 1, 1)); // down wrap
        vecs.push_back(mk(0, 1, 3'b001, 4'h5, 0, 0, 4'h5, 1, 0));
        for (int m = 0; m < 8; m++)                                  // EN=0 gating
            vecs.push_back(mk(0, 0, m[2:0], 4'hC, 1, 1, 4'h5, 1, 0));
        vecs.push_back(mk(0, 1, 3'b110, 4'h0, 0, 0, 4'h6, 1, 0));
        vecs.push_back(mk(0, 1, 3'b001, 4'hF, 0, 0, 4'hF, 1, 0));
        vecs.push_back(mk(1, 1, 3'b110, 4'h0, 0, 0, 4'hA, 0, 0)); // reset on wrap edge
        vecs.push_back(mk(0, 1, 3'b000, 4'h0, 1, 1, 4'hA, 0, 0)); // no late TC
        vecs.push_back(mk(0, 1, 3'b001, 4'hF, 0, 0, 4'hF, 0, 0));
        vecs.push_back(mk(0, 1, 3'b110, 4'h0, 0, 0, 4'h0, 0, 1));
        vecs.push_back(mk(0, 0, 3'b110, 4'h0, 0, 0, 4'h0, 0, 0)); // TC drops when EN=0

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sil, vecs[i].sir);
            chk("q", i, Q, vecs[i].q);
            chk("qbar", i, Qbar, ~vecs[i].q);
            chk("so", i, {3'b000, SO}, {3'b000, vecs[i].so});
            chk("tc", i, {3'b000, TC}, {3'b000, vecs[i].tc});
        end

        // Randomized phase; model starts from a known reset.
        apply(1, 0, 3'b000, 4'h0, 0, 0);
        mq = 10; mso = 0; mtc = 0;
        for (int n = 0; n < 400; n++) begin
            logic       r, en, sil, sir;
            logic [2:0] mode;
            logic [3:0] d;
            r    = ($urandom_range(0, 24) == 0);
            en   = ($urandom_range(0, 4) != 0);
            mode = 3'($urandom_range(0, 7));
            d    = 4'($urandom_range(0, 15));
            sil  = 1'($urandom_range(0, 1));
            sir  = 1'($urandom_range(0, 1));
            apply(r, en, mode, d, sil, sir);

            old = mq;
            mtc = 0;
            if (r) begin
                mq = 10; mso = 0;
            end else if (en) begin
                case (int'(mode))
                    1: mq = int'(d);
                    2: begin mso = old / 8; mq = (old * 2 + int'(sil)) % 16; end
                    3: begin mso = old % 2; mq = old / 2 + int'(sir) * 8; end
                    4: begin mso = old / 8; mq = (old * 2 + old / 8) % 16; end
                    5: begin mso = old % 2; mq = old / 2 + (old % 2) * 8; end
                    6: begin mtc = (old == 15) ? 1 : 0; mq = (old + 1) % 16; end
                    7: begin mtc = (old == 0) ? 1 : 0; mq = (old + 15) % 16; end
                    default: mq = old;
                endcase
            end
            chk("rnd_q", n, Q, 4'(mq));
            chk("rnd_qbar", n, Qbar, 4'(15 - mq));
            chk("rnd_so", n, {3'b000, SO}, 4'(mso));
            chk("rnd_tc", n, {3'b000, TC}, 4'(mtc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
